// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute/write-back unit.
//   DATA_W / RADDR_W : default register-file word width and address width
//   OP_*             : 3-bit opcodes
//   state_t          : control FSM states
//   FLAG_*           : bit positions inside the {N,C,Z} flags vector
package alu_exec_pkg;

    localparam int DATA_W  = 8;
    localparam int RADDR_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        MUL  = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

endpackage

// File: rtl/alu_exec_if.sv
// Bus between the execute unit, its command source and the 16x8 register file.
//   Command side : start, op, src_a, src_b, dst  ->  busy, done, flags
//   Regfile side : address_A/B (async read), address_D/data_in (write every
//                  falling edge), out_A/out_B (read data back)
// modport slave  : the execute unit
// modport master : command source plus register file (e.g. a testbench)
interface alu_exec_if #(
    parameter int WIDTH  = alu_exec_pkg::DATA_W,
    parameter int ADDR_W = alu_exec_pkg::RADDR_W
);
    logic              start;
    logic [2:0]        op;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [ADDR_W-1:0] dst;
    logic              busy;
    logic              done;
    logic [2:0]        flags;
    logic [ADDR_W-1:0] address_A;
    logic [ADDR_W-1:0] address_B;
    logic [ADDR_W-1:0] address_D;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  out_A;
    logic [WIDTH-1:0]  out_B;

    modport slave (
        input  start, op, src_a, src_b, dst, out_A, out_B,
        output busy, done, flags, address_A, address_B, address_D, data_in
    );

    modport master (
        output start, op, src_a, src_b, dst, out_A, out_B,
        input  busy, done, flags, address_A, address_B, address_D, data_in
    );
endinterface

// File: rtl/alu_exec_unit_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, LSB first.
//   clk, srst     : clock, synchronous active-high reset
//   load          : capture a (multiplicand) and b (multiplier), clear acc/count
//   step          : perform one add-and-shift iteration
//   product_next  : value the accumulator takes at the end of the current step
//   last_step     : high while the final (WIDTH-th) iteration is in progress
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product_next,
    output logic               last_step
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] acc_next;

    always_comb begin
        acc_next = acc_reg;
        if (mplier_reg[0]) begin
            acc_next = acc_reg + mcand_reg;
        end
    end

    // Exposing the next accumulator value lets the caller register the final
    // product on the same edge that completes the last iteration.
    assign product_next = acc_next;
    assign last_step    = (count_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (srst) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
        end else if (load) begin
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            count_reg  <= '0;
        end else if (step) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// Execute/write-back stage beside a 16x8 register file.
//   nclk  : clock (all flops rising edge; the register file writes on falling edge)
//   reset : synchronous, active-high
//   bus   : command handshake (start/op/src_a/src_b/dst -> busy/done/flags)
//           and register-file ports (address_A/B/D, data_in, out_A/B)
// One command: IDLE -> READ -> [MUL x8] -> WB -> IDLE.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int ADDR_W = RADDR_W
) (
    input  logic      nclk,
    input  logic      reset,
    alu_exec_if.slave bus
);
    state_t             state_reg, state_next;
    logic [2:0]         op_reg;
    logic [ADDR_W-1:0]  src_a_reg, src_b_reg, dst_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [2:0]         flags_reg;

    logic [WIDTH:0]     sum_ext, diff_ext;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_carry;
    logic [2:0]         alu_flags, mul_flags;
    logic [2*WIDTH-1:0] prod_next;
    logic               mul_last;
    logic               wb_write;

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk          (nclk),
        .srst         (reset),
        .load         (state_reg == READ),
        .step         (state_reg == MUL),
        .a            (bus.out_A),
        .b            (bus.out_B),
        .product_next (prod_next),
        .last_step    (mul_last)
    );

    // Single-cycle ALU working straight off the register-file read data
    // during READ.
    always_comb begin
        sum_ext    = {1'b0, bus.out_A} + {1'b0, bus.out_B};
        diff_ext   = {1'b0, bus.out_A} - {1'b0, bus.out_B};
        alu_result = '0;
        alu_carry  = 1'b0;
        case (op_reg)
            OP_ADD: begin
                alu_result = sum_ext[WIDTH-1:0];
                alu_carry  = sum_ext[WIDTH];
            end
            OP_SUB, OP_CMP: begin
                alu_result = diff_ext[WIDTH-1:0];
                alu_carry  = diff_ext[WIDTH];  // borrow: A < B
            end
            OP_AND: alu_result = bus.out_A & bus.out_B;
            OP_OR:  alu_result = bus.out_A | bus.out_B;
            OP_XOR: alu_result = bus.out_A ^ bus.out_B;
            OP_SHL: begin
                alu_result = {bus.out_A[WIDTH-2:0], 1'b0};
                alu_carry  = bus.out_A[WIDTH-1];
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_Z] = (alu_result == '0);
        alu_flags[FLAG_C] = alu_carry;
        alu_flags[FLAG_N] = alu_result[WIDTH-1];
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (prod_next[WIDTH-1:0] == '0);
        mul_flags[FLAG_C] = |prod_next[2*WIDTH-1:WIDTH];
        mul_flags[FLAG_N] = prod_next[WIDTH-1];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = READ;
            READ:    state_next = (op_reg == OP_MUL) ? MUL : WB;
            MUL:     if (mul_last) state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge nclk) begin
        if (reset) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            src_a_reg  <= '0;
            src_b_reg  <= '0;
            dst_reg    <= '0;
            result_reg <= '0;
            flags_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && bus.start) begin
                op_reg    <= bus.op;
                src_a_reg <= bus.src_a;
                src_b_reg <= bus.src_b;
                dst_reg   <= bus.dst;
            end
            if (state_reg == READ && op_reg != OP_MUL) begin
                result_reg <= alu_result;
                flags_reg  <= alu_flags;
            end
            if (state_reg == MUL && mul_last) begin
                result_reg <= prod_next[WIDTH-1:0];
                flags_reg  <= mul_flags;
            end
        end
    end

    // The register file writes on every falling edge with no enable, so
    // whenever no real write is wanted the write port is pointed at read
    // port B with its own data, turning the write into a harmless refresh.
    assign wb_write      = (state_reg == WB) && (op_reg != OP_CMP);
    assign bus.address_A = (state_reg == READ) ? src_a_reg : '0;
    assign bus.address_B = (state_reg == READ) ? src_b_reg : '0;
    assign bus.address_D = wb_write ? dst_reg    : bus.address_B;
    assign bus.data_in   = wb_write ? result_reg : bus.out_B;

    assign bus.busy  = (state_reg != IDLE);
    assign bus.done  = (state_reg == WB);
    assign bus.flags = flags_reg;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a behavioural 16x8 register file
// (async read, write on every falling edge, initialised to Rn = n).
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    logic nclk = 1'b0;
    logic reset;
    always #5 nclk = ~nclk;

    alu_exec_if bus ();

    alu_exec_unit dut (
        .nclk  (nclk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] rf [16];
    logic [7:0] exp_rf [16];
    logic       rf_load;

    assign bus.out_A = rf[bus.address_A];
    assign bus.out_B = rf[bus.address_B];

    always @(negedge nclk) begin
        if (rf_load) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'(i);
        end else begin
            rf[bus.address_D] <= bus.data_in;
        end
    end

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s R%0d", tag, i), 32'(rf[i]), 32'(exp_rf[i]));
        end
    endtask

    // Issue one command, check done latency, flags and the written register.
    task automatic run_cmd(input string name, input logic [2:0] op,
                           input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                           input logic [7:0] exp_val, input logic [2:0] exp_flags,
                           input int exp_lat);
        int cyc;
        @(posedge nclk); #1;
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.dst = d;
        @(posedge nclk); #1;
        // Scramble command inputs: they must only matter on the accepting edge.
        bus.start = 1'b0; bus.op = ~op; bus.src_a = ~a; bus.src_b = ~b; bus.dst = ~d;
        cyc = 1;
        while (!bus.done && cyc < 30) begin
            @(posedge nclk); #1;
            cyc++;
        end
        check({name, " done cycle"}, 32'(cyc), 32'(exp_lat));
        check({name, " busy in WB"}, 32'(bus.busy), 32'(1));
        check({name, " flags"}, 32'(bus.flags), 32'(exp_flags));
        if (op != OP_CMP) exp_rf[d] = exp_val;
        @(posedge nclk); #1;
        check({name, " busy after"}, 32'(bus.busy), 32'(0));
        check({name, " done after"}, 32'(bus.done), 32'(0));
        check({name, " reg"}, 32'(rf[d]), 32'(exp_rf[d]));
    endtask

    int dones;

    initial begin
        reset = 1'b1; rf_load = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.dst = '0;
        for (int i = 0; i < 16; i++) exp_rf[i] = 8'(i);
        repeat (3) @(posedge nclk);
        #1;
        check("reset busy", 32'(bus.busy), 32'(0));
        check("reset done", 32'(bus.done), 32'(0));
        check("reset flags", 32'(bus.flags), 32'(0));
        check("reset address_A", 32'(bus.address_A), 32'(0));
        check("reset address_D", 32'(bus.address_D), 32'(0));
        rf_load = 1'b0;
        reset   = 1'b0;

        //       name    op      A      B      D      value  {N,C,Z} cycle
        run_cmd("ADD",  OP_ADD, 4'd3,  4'd5,  4'd7,  8'h08, 3'b000, 2);
        run_cmd("SUB",  OP_SUB, 4'd2,  4'd5,  4'd1,  8'hFD, 3'b110, 2);
        run_cmd("CMP",  OP_CMP, 4'd4,  4'd4,  4'd9,  8'h00, 3'b001, 2);
        check_all_regs("after CMP");
        run_cmd("MUL1", OP_MUL, 4'd15, 4'd15, 4'd0,  8'hE1, 3'b100, 10);
        run_cmd("MUL2", OP_MUL, 4'd15, 4'd9,  4'd2,  8'h87, 3'b100, 10);
        run_cmd("MUL3", OP_MUL, 4'd15, 4'd14, 4'd3,  8'hD2, 3'b100, 10);
        run_cmd("MULC", OP_MUL, 4'd1,  4'd15, 4'd4,  8'hD3, 3'b110, 10);
        run_cmd("ADDC", OP_ADD, 4'd1,  4'd5,  4'd10, 8'h02, 3'b010, 2);
        run_cmd("SHL",  OP_SHL, 4'd1,  4'd0,  4'd11, 8'hFA, 3'b110, 2);
        run_cmd("AND",  OP_AND, 4'd12, 4'd6,  4'd12, 8'h04, 3'b000, 2);
        run_cmd("OR",   OP_OR,  4'd8,  4'd6,  4'd13, 8'h0E, 3'b000, 2);
        run_cmd("XOR",  OP_XOR, 4'd5,  4'd5,  4'd14, 8'h00, 3'b001, 2);
        run_cmd("SUBB", OP_SUB, 4'd5,  4'd2,  4'd8,  8'h7E, 3'b010, 2);

        repeat (20) @(posedge nclk);
        #1;
        check_all_regs("idle readback");

        // Reset in the fifth MUL cycle must abort without writing R6.
        @(posedge nclk); #1;
        bus.start = 1'b1; bus.op = OP_MUL; bus.src_a = 4'd2; bus.src_b = 4'd3; bus.dst = 4'd6;
        @(posedge nclk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge nclk);
        #1;
        check("pre-reset busy", 32'(bus.busy), 32'(1));
        reset = 1'b1;
        @(posedge nclk); #1;
        reset = 1'b0;
        check("abort busy", 32'(bus.busy), 32'(0));
        check("abort done", 32'(bus.done), 32'(0));
        check("abort flags", 32'(bus.flags), 32'(0));
        @(posedge nclk); #1;
        check("abort R6", 32'(rf[6]), 32'(8'd6));

        // start held through busy with a different command: only one executes.
        @(posedge nclk); #1;
        bus.start = 1'b1; bus.op = OP_ADD; bus.src_a = 4'd3; bus.src_b = 4'd4; bus.dst = 4'd5;
        @(posedge nclk); #1;
        bus.op = OP_SUB; bus.src_a = 4'd0; bus.src_b = 4'd0; bus.dst = 4'd9;
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.done) begin
                dones++;
                @(posedge nclk); #1;
                bus.start = 1'b0;
            end else begin
                @(posedge nclk); #1;
            end
        end
        exp_rf[5] = 8'hA5;
        check("held start done count", 32'(dones), 32'(1));
        check("held start flags", 32'(bus.flags), 32'(3'b110));
        check_all_regs("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
